// File: rtl/add_arbiter_pkg.sv
// Shared control definitions for the add_arbiter sequencer: FSM state
// encoding, status word bit positions and the state-to-status decode.
package add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    RESP = 2'b11
  } state_e;

  localparam int DONE_BIT  = 0;
  localparam int BUSY_BIT  = 1;
  localparam int READY_BIT = 2;

  // Status word presented while the FSM sits in state s.
  function automatic logic [2:0] status_of(input state_e s);
    logic [2:0] st;
    st = '0;
    case (s)
      LOAD:    st[READY_BIT] = 1'b1;
      RUN:     st[BUSY_BIT]  = 1'b1;
      RESP:    st[DONE_BIT]  = 1'b1;
      default: st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// Requester-side bus of the add_arbiter: request levels, packed operands,
// abort, and the ack/result/status returned by the arbiter.
interface add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 3
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]   req_i;
  logic [NREQ*W-1:0] a_i;
  logic [NREQ*W-1:0] b_i;
  logic              abort_i;
  logic [NREQ-1:0]   ack_o;
  logic [W-1:0]      sum_o;
  logic              carry_o;
  logic [GW-1:0]     grant_id_o;
  logic [2:0]        status_o;
  logic [7:0]        jobs_done_o;

  modport master (
    output req_i, a_i, b_i, abort_i,
    input  ack_o, sum_o, carry_o, grant_id_o, status_o, jobs_done_o
  );

  modport slave (
    input  req_i, a_i, b_i, abort_i,
    output ack_o, sum_o, carry_o, grant_id_o, status_o, jobs_done_o
  );

endinterface

// File: rtl/add_arbiter_engine.sv
// Multi-cycle adder engine: the sum is registered on start, and a down-counter
// models the compute latency. done is high for the single cycle in which the
// counter reads 1, i.e. the last of LAT busy cycles. clear cancels a job.
module add_engine #(
  parameter int W   = 3,
  parameter int LAT = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clear,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         carry
);
  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] cnt_q;
  logic [W:0]    res_q;

  // Latency counter and registered W+1-bit sum; clear beats start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      res_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= CW'(LAT);
      res_q <= {1'b0, a} + {1'b0, b};
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done  = (cnt_q == CW'(1));
  assign sum   = res_q[W-1:0];
  assign carry = res_q[W];

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one add_engine among NREQ requesters.
// IDLE grants and latches operands, LOAD starts the engine, RUN waits for
// done, RESP pulses ack with the registered result. All outputs registered.
module add_arbiter
  import add_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 3,
  parameter int LAT  = 5
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  add_arbiter_if.slave  bus
);
  localparam int GW = $clog2(NREQ);

  state_e          state_q;
  logic [NREQ-1:0] ack_q;
  logic [W-1:0]    sum_q;
  logic            carry_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   last_q;
  logic [2:0]      status_q;
  logic [7:0]      jobs_q;
  logic [W-1:0]    opa_q;
  logic [W-1:0]    opb_q;

  logic [GW-1:0]   pick_d;
  logic [W-1:0]    mux_a_d;
  logic [W-1:0]    mux_b_d;
  logic            eng_start;
  logic            eng_clear;
  logic            eng_done;
  logic [W-1:0]    eng_sum;
  logic            eng_carry;

  // First requesting index searching upward from last_q+1; scanning from the
  // far end lets the nearest candidate overwrite the others.
  always_comb begin
    pick_d = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (bus.req_i[(int'(last_q) + i) % NREQ]) begin
        pick_d = GW'((int'(last_q) + i) % NREQ);
      end
    end
    mux_a_d = bus.a_i[int'(pick_d)*W +: W];
    mux_b_d = bus.b_i[int'(pick_d)*W +: W];
  end

  assign eng_start = (state_q == LOAD);
  assign eng_clear = bus.abort_i && ((state_q == LOAD) || (state_q == RUN));

  add_engine #(
    .W   (W),
    .LAT (LAT)
  ) u_engine (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .start (eng_start),
    .clear (eng_clear),
    .a     (opa_q),
    .b     (opb_q),
    .done  (eng_done),
    .sum   (eng_sum),
    .carry (eng_carry)
  );

  // Sequencer FSM with registered ack, result, status and job counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= IDLE;
      ack_q    <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      grant_q  <= '0;
      last_q   <= GW'(NREQ - 1);
      status_q <= '0;
      jobs_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (|bus.req_i) begin
            opa_q    <= mux_a_d;
            opb_q    <= mux_b_d;
            grant_q  <= pick_d;
            state_q  <= LOAD;
            status_q <= status_of(LOAD);
          end
        end
        LOAD: begin
          if (bus.abort_i) begin
            state_q  <= IDLE;
            status_q <= status_of(IDLE);
          end else begin
            state_q  <= RUN;
            status_q <= status_of(RUN);
          end
        end
        RUN: begin
          // Abort wins even when it coincides with done.
          if (bus.abort_i) begin
            state_q  <= IDLE;
            status_q <= status_of(IDLE);
          end else if (eng_done) begin
            state_q  <= RESP;
            status_q <= status_of(RESP);
            ack_q    <= {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
            sum_q    <= eng_sum;
            carry_q  <= eng_carry;
            last_q   <= grant_q;
            jobs_q   <= jobs_q + 8'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          status_q <= status_of(IDLE);
        end
      endcase
    end
  end

  assign bus.ack_o       = ack_q;
  assign bus.sum_o       = sum_q;
  assign bus.carry_o     = carry_q;
  assign bus.grant_id_o  = grant_q;
  assign bus.status_o    = status_q;
  assign bus.jobs_done_o = jobs_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: directed cases plus randomized jobs checked against
// a job-level reference (round-robin pick, W+1-bit sum, job count mod 256).
module tb_add_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 3;
  localparam int LAT  = 5;
  localparam int AW   = NREQ * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_last;
  int   m_jobs;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  add_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (bus)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Round-robin rule: first set bit strictly after the last served index.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      if (r[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return 0;
  endfunction

  // Starts at a negedge with the DUT idle; returns at a negedge with it idle.
  // Cycle 1 is the LOAD cycle after the sampling edge; ack lands in LAT+2.
  task automatic do_job(input logic [NREQ-1:0] req, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, input int abort_at, input bit scramble,
                        output logic [NREQ-1:0] ack_seen, output int ack_cyc);
    int g;
    int esum;
    logic [NREQ-1:0] e_ack;
    logic [2:0] e_st;
    ack_seen = '0;
    ack_cyc  = 0;
    bus.req_i = req;
    bus.a_i   = a;
    bus.b_i   = b;
    g    = rr_pick(req, m_last);
    esum = int'(a[g*W +: W]) + int'(b[g*W +: W]);
    @(posedge clk);
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      e_ack = '0;
      if (abort_at > 0 && c > abort_at) e_st = 3'b000;
      else if (c == 1)                  e_st = 3'b100;
      else if (c <= LAT + 1)            e_st = 3'b010;
      else begin
        e_st  = 3'b001;
        e_ack = NREQ'(1) << g;
      end
      chk_eq("ack_status", {bus.ack_o, bus.status_o}, {e_ack, e_st});
      if (c == 1) begin
        chk_eq("grant_id", bus.grant_id_o, g);
        if (scramble) begin
          bus.a_i   = AW'($urandom);
          bus.b_i   = AW'($urandom);
          bus.req_i = NREQ'($urandom);
        end
      end
      if (c == LAT + 2 && abort_at == 0) begin
        ack_seen = bus.ack_o;
        ack_cyc  = cyc;
        m_jobs   = (m_jobs + 1) % 256;
        m_last   = g;
        chk_eq("sum", bus.sum_o, esum % (1 << W));
        chk_eq("carry", bus.carry_o, esum >> W);
        chk_eq("jobs", bus.jobs_done_o, m_jobs);
      end
      if (c == abort_at) begin
        bus.abort_i = 1'b1;
        bus.req_i   = '0;
      end else begin
        bus.abort_i = 1'b0;
      end
    end
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk_eq("idle", {bus.ack_o, bus.status_o}, '0);
    if (abort_at > 0) chk_eq("jobs_abort", bus.jobs_done_o, m_jobs);
  endtask

  initial begin
    logic [AW-1:0]   a;
    logic [AW-1:0]   b;
    logic [NREQ-1:0] ack_seen;
    int              ack_cyc;
    int              prev_cyc;
    int              iter;
    int              ab;
    bus.req_i   = '0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.abort_i = 1'b0;
    m_last = NREQ - 1;
    m_jobs = 0;
    repeat (2) @(negedge clk);
    chk_eq("reset", {bus.ack_o, bus.sum_o, bus.carry_o, bus.grant_id_o, bus.status_o, bus.jobs_done_o}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single job on requester 0.
    a = '0; b = '0;
    a[0 +: W] = 3'd3; b[0 +: W] = 3'd2;
    do_job(4'b0001, a, b, 0, 1'b0, ack_seen, ack_cyc);
    chk_eq("single_ack", ack_seen, 4'b0001);
    chk_eq("single_sum", bus.sum_o, 5);
    chk_eq("single_carry", bus.carry_o, 0);
    chk_eq("single_jobs", bus.jobs_done_o, 1);

    // Overflow on requester 1; result held after ack.
    a = '0; b = '0;
    a[W +: W] = 3'd7; b[W +: W] = 3'd6;
    do_job(4'b0010, a, b, 0, 1'b1, ack_seen, ack_cyc);
    chk_eq("ovf_ack", ack_seen, 4'b0010);
    chk_eq("ovf_sum", bus.sum_o, 5);
    chk_eq("ovf_carry", bus.carry_o, 1);

    // Abort during RUN: no ack, count kept, same requester regranted.
    do_job(4'b0100, AW'($urandom), AW'($urandom), 3, 1'b0, ack_seen, ack_cyc);
    chk_eq("abort_noack", ack_seen, '0);
    chk_eq("abort_jobs", bus.jobs_done_o, 2);
    chk_eq("abort_sum_kept", bus.sum_o, 5);
    do_job(4'b1111, AW'($urandom), AW'($urandom), 0, 1'b0, ack_seen, ack_cyc);
    chk_eq("abort_regrant", ack_seen, 4'b0100);

    // Asynchronous reset in the middle of RUN.
    bus.req_i = 4'b1000;
    bus.a_i   = AW'($urandom);
    bus.b_i   = AW'($urandom);
    @(posedge clk);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_eq("rst_midrun", {bus.ack_o, bus.sum_o, bus.carry_o, bus.grant_id_o, bus.status_o, bus.jobs_done_o}, '0);
    bus.req_i = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = NREQ - 1;
    m_jobs = 0;
    @(negedge clk);

    // Fairness with all requests held: 0,1,2,3,0, LAT+3 cycles apart.
    prev_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      do_job(4'b1111, AW'($urandom), AW'($urandom), 0, 1'b0, ack_seen, ack_cyc);
      chk_eq("fair_ack", ack_seen, NREQ'(1) << (i % NREQ));
      if (i > 0) chk_eq("fair_gap", ack_cyc - prev_cyc, LAT + 3);
      prev_cyc = ack_cyc;
    end

    // Random jobs with occasional aborts until the job counter wraps.
    iter = 0;
    do begin
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, LAT + 1)) : 0;
      do_job(NREQ'($urandom_range(1, (1 << NREQ) - 1)), AW'($urandom), AW'($urandom),
             ab, 1'b1, ack_seen, ack_cyc);
      iter++;
    end while (m_jobs != 0 && iter < 600);
    chk_eq("wrap", bus.jobs_done_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
